uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//   Serial UART transmit engine with selectable baud rate and 16x oversampled bit timing.
//   Accepts one byte per write; emits start, 8 data bits LSB-first, optional even parity, stop.
//   Sits between a host write interface and the TxD line; Tx_BUSY tells the host when it may write.
// PARAMETERS
//   CLK_FREQ_HZ   50_000_000   system clock frequency, used for baud divisor computation
//   OVERSAMPLE    16           sample ticks per bit period
// PORTS
//   clk          in   1  system clock, all state on rising edge
//   reset        in   1  asynchronous, active-low reset (0 = reset)
//   Tx_DATA      in   8  byte to send, captured on accepted write
//   baud_select  in   3  baud rate code, captured on accepted write
//   Tx_WR        in   1  write request, level-sampled each clk
//   Tx_EN        in   1  transmitter enable
//   TxD          out  1  serial line, idle high
//   Tx_BUSY      out  1  frame in progress
// BEHAVIOUR
//   Reset: TxD=1, Tx_BUSY=0, state IDLE, tick counter=0, bit counter=0, data register=0.
//   Baud codes -> divisor (clk cycles per tick) = round(CLK_FREQ_HZ/(OVERSAMPLE*baud)):
//     000:300->10417  001:1200->2604  010:4800->651  011:9600->326
//     100:19200->163  101:38400->81   110:57600->54  111:115200->27
//   Accept: on a clk edge with Tx_EN=1, Tx_WR=1, Tx_BUSY=0 -> latch Tx_DATA and baud_select,
//     clear tick divider, Tx_BUSY=1 and TxD=0 (start bit) from the next cycle.
//   Writes while Tx_BUSY=1 are ignored. Tx_WR held high -> back-to-back frames, one idle cycle between.
//   States: IDLE -> START -> DATA(8 bits, bit0 first) -> PARITY (macro only) -> STOP -> IDLE.
//   Each bit lasts exactly OVERSAMPLE ticks = OVERSAMPLE*divisor clk cycles; at code 111 = 432 cycles.
//   Transition when the 16th tick of a bit completes; DATA uses 3-bit index, exits after index 7.
//   STOP drives TxD=1; Tx_BUSY drops in the cycle IDLE is re-entered.
//   Tx_EN=0 at any time: frame aborted, TxD=1, Tx_BUSY=0 next edge, counters cleared.
//   baud_select / Tx_DATA changes mid-frame have no effect on the current frame.
//   Reset asserted mid-frame: outputs return to reset values immediately (asynchronous).
//   TxD and Tx_BUSY are registered outputs (no combinational paths from inputs).
// CONFIGURATION
//   UART_TX_PARITY_EN defined: 11-bit frame; PARITY bit = XOR of 8 latched data bits (even parity).
//   UART_TX_PARITY_EN undefined: 10-bit frame; STOP directly follows data bit 7.
// STRUCTURE
//   Shared package uart_pkg: state encoding constants, baud-code localparams, divisor function.
//   Sub-module uart_baud_controller: baud_select + clk/reset -> one-cycle sample_tick every
//   divisor cycles; counter restart input asserted on frame accept.
//   Top holds FSM, data shift register, tick counter (0..15), bit index, parity.
// TESTING
//   Reset held low 400 ns then released -> TxD=1, Tx_BUSY=0, no activity with Tx_WR=0.
//   Tx_EN=1, code 111, Tx_DATA=8'h17, Tx_WR=1 -> TxD 0,1,1,1,0,1,0,0,0,[parity 0],1 at 432 cycles/bit;
//     Tx_BUSY high for 4752 cycles with parity (4320 without).
//   Code 011, Tx_DATA=8'hA5 -> bit period 5216 cycles; parity bit 0; LSB 1 first after start.
//   Tx_DATA changed and second Tx_WR pulsed mid-frame -> ignored; Tx_WR held high -> second
//     identical frame starts after one idle cycle.
//   Tx_EN dropped during data bit 3 -> TxD=1, Tx_BUSY=0 next cycle; new write sends full frame.
//   Tx_EN=0 with Tx_WR=1 -> no frame; reset pulsed mid-frame -> immediate TxD=1, Tx_BUSY=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding, baud-rate codes and
// the elaboration-time clock-divisor table.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [2:0] BAUD_300    = 3'd0;
    localparam logic [2:0] BAUD_1200   = 3'd1;
    localparam logic [2:0] BAUD_4800   = 3'd2;
    localparam logic [2:0] BAUD_9600   = 3'd3;
    localparam logic [2:0] BAUD_19200  = 3'd4;
    localparam logic [2:0] BAUD_38400  = 3'd5;
    localparam logic [2:0] BAUD_57600  = 3'd6;
    localparam logic [2:0] BAUD_115200 = 3'd7;

    // Wide enough for the 300 baud divisor at 50 MHz (10417)
    localparam int DIV_W = 14;

    typedef logic [7:0][DIV_W-1:0] div_table_t;

    function automatic int baud_rate(input logic [2:0] code);
        case (code)
            BAUD_300:    return 300;
            BAUD_1200:   return 1200;
            BAUD_4800:   return 4800;
            BAUD_9600:   return 9600;
            BAUD_19200:  return 19200;
            BAUD_38400:  return 38400;
            BAUD_57600:  return 57600;
            default:     return 115200;
        endcase
    endfunction

    // Rounded clk cycles per sample tick, evaluated only at elaboration so no
    // runtime divider is built.
    function automatic div_table_t divisor_table(input int clk_hz, input int os);
        div_table_t t;
        int den;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            den  = os * baud_rate(3'(i));
            t[i] = DIV_W'((clk_hz + den / 2) / den);
        end
        return t;
    endfunction

endpackage

// File: rtl/uart_baud_controller.sv
// Sample-tick generator: one-cycle sample_tick every divisor clk cycles for the
// selected baud code; restart holds the divider at zero.
module uart_baud_controller
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       restart,
    output logic       sample_tick
);

    localparam div_table_t DIV_TAB = divisor_table(CLK_FREQ_HZ, OVERSAMPLE);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;

    assign div         = DIV_TAB[baud_select];
    assign sample_tick = !restart && (cnt == div - DIV_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (restart || sample_tick)
            cnt <= '0;
        else
            cnt <= cnt + DIV_W'(1);
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit engine: start, 8 data bits LSB-first, optional even parity
// (UART_TX_PARITY_EN), stop; 16x oversampled bit timing, registered TxD/Tx_BUSY.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Tx_DATA,
    input  logic [2:0] baud_select,
    input  logic       Tx_WR,
    input  logic       Tx_EN,
    output logic       TxD,
    output logic       Tx_BUSY
);

    localparam int TICK_W = $clog2(OVERSAMPLE);

    tx_state_e         state_q, state_d;
    logic [2:0]        bit_idx, idx_d;
    logic [7:0]        data_q;
    logic [2:0]        baud_q;
    logic [TICK_W-1:0] tick_cnt;
    logic              sample_tick, bit_done, accept;
    logic              txd_d, busy_d;

    assign accept   = Tx_EN && Tx_WR && !Tx_BUSY;
    assign bit_done = sample_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));

    // Divider is held cleared while idle so the accept edge starts a fresh bit
    uart_baud_controller #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .OVERSAMPLE  (OVERSAMPLE)
    ) u_baud (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_q),
        .restart     ((state_q == ST_IDLE) || !Tx_EN),
        .sample_tick (sample_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            bit_idx <= '0;
        end else begin
            state_q <= state_d;
            bit_idx <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = bit_idx;
        if (!Tx_EN) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE:   if (accept) state_d = ST_START;
                ST_START: begin
                    idx_d = '0;
                    if (bit_done) state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                            idx_d = '0;
                        end else begin
                            idx_d = bit_idx + 3'd1;
                        end
                    end
                end
                ST_PARITY: if (bit_done) state_d = ST_STOP;
                ST_STOP:   if (bit_done) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the next state so the flops present the new bit
    // in the same cycle the state register changes.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = data_q[idx_d];
            ST_PARITY: txd_d = ^data_q;
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            TxD      <= 1'b1;
            Tx_BUSY  <= 1'b0;
            data_q   <= '0;
            baud_q   <= '0;
            tick_cnt <= '0;
        end else begin
            TxD     <= txd_d;
            Tx_BUSY <= busy_d;
            if (accept) begin
                data_q <= Tx_DATA;
                baud_q <= baud_select;
            end
            if (state_q == ST_IDLE || state_d == ST_IDLE)
                tick_cnt <= '0;
            else if (bit_done)
                tick_cnt <= '0;
            else if (sample_tick)
                tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter; frame constants follow UART_TX_PARITY_EN.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Tx_DATA;
    logic [2:0] baud_select;
    logic       Tx_WR, Tx_EN;
    logic       TxD, Tx_BUSY;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .Tx_DATA     (Tx_DATA),
        .baud_select (baud_select),
        .Tx_WR       (Tx_WR),
        .Tx_EN       (Tx_EN),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY)
    );

    // Bit i of a frame constant is the i-th bit on the line (start first)
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS    = 11;
    localparam logic [10:0] FRAME_17 = 11'b1_0_00010111_0;
    localparam logic [10:0] FRAME_A5 = 11'b1_0_10100101_0;
`else
    localparam int          NBITS    = 10;
    localparam logic [10:0] FRAME_17 = 11'b0_1_00010111_0;
    localparam logic [10:0] FRAME_A5 = 11'b0_1_10100101_0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic [2:0] code, input bit hold);
        @(negedge clk);
        Tx_DATA     = d;
        baud_select = code;
        Tx_WR       = 1'b1;
        @(negedge clk);
        if (!hold) Tx_WR = 1'b0;
    endtask

    // Entered at the negedge of the first frame cycle; leaves at the first idle cycle
    task automatic run_frame(input string tag, input logic [10:0] exp, input int bitlen, input bit poke);
        int cyc = 1;
        int b;
        chk({tag, " busy start"}, 32'(Tx_BUSY), 32'd1);
        while (Tx_BUSY && cyc < NBITS * bitlen + 10) begin
            b = (cyc - 1) / bitlen;
            if ((cyc - 1) % bitlen == bitlen / 2 && b < NBITS)
                chk($sformatf("%s bit%0d", tag, b), 32'(TxD), 32'(exp[b]));
            if (poke && cyc == 1000) begin
                Tx_DATA     = 8'hFF;
                baud_select = 3'b000;
                Tx_WR       = 1'b1;
            end
            if (poke && cyc == 1001) Tx_WR = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " busy len"}, 32'(cyc - 1), 32'(NBITS * bitlen));
        chk({tag, " idle txd"}, 32'(TxD), 32'd1);
    endtask

    initial begin
        bit seen;
        reset       = 1'b0;
        Tx_DATA     = '0;
        baud_select = '0;
        Tx_WR       = 1'b0;
        Tx_EN       = 1'b0;
        #400;
        chk("rst txd", 32'(TxD), 32'd1);
        chk("rst busy", 32'(Tx_BUSY), 32'd0);
        #2 reset = 1'b1;

        Tx_EN = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (Tx_BUSY || !TxD) seen = 1'b1;
        end
        chk("idle no activity", 32'(seen), 32'd0);

        // 0x17 at 115200: 432 cycles/bit, mid-frame data/baud change and Tx_WR pulse ignored
        wr_byte(8'h17, 3'b111, 1'b0);
        run_frame("f17", FRAME_17, 432, 1'b1);
        repeat (5) @(negedge clk);
        chk("f17 no retrigger", 32'(Tx_BUSY), 32'd0);

        // Tx_WR held: second identical frame after exactly one idle cycle
        wr_byte(8'h17, 3'b111, 1'b1);
        run_frame("b2b1", FRAME_17, 432, 1'b0);
        @(negedge clk);
        Tx_WR = 1'b0;
        run_frame("b2b2", FRAME_17, 432, 1'b0);

        // Abort during data bit 3 (a 0 for 0x17)
        wr_byte(8'h17, 3'b111, 1'b0);
        repeat (4 * 432 + 100 - 1) @(negedge clk);
        chk("abort pre txd", 32'(TxD), 32'd0);
        chk("abort pre busy", 32'(Tx_BUSY), 32'd1);
        Tx_EN = 1'b0;
        @(negedge clk);
        chk("abort txd", 32'(TxD), 32'd1);
        chk("abort busy", 32'(Tx_BUSY), 32'd0);
        Tx_EN = 1'b1;
        repeat (3) @(negedge clk);

        // Fresh full frame after abort, 9600 baud: 5216 cycles/bit
        wr_byte(8'hA5, 3'b011, 1'b0);
        run_frame("fa5", FRAME_A5, 5216, 1'b0);

        Tx_EN = 1'b0;
        Tx_WR = 1'b1;
        seen  = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (Tx_BUSY || !TxD) seen = 1'b1;
        end
        chk("en0 no frame", 32'(seen), 32'd0);
        Tx_WR = 1'b0;
        Tx_EN = 1'b1;

        // Asynchronous reset in the middle of the start bit
        wr_byte(8'h17, 3'b111, 1'b0);
        repeat (199) @(negedge clk);
        chk("mid pre txd", 32'(TxD), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("mid rst txd", 32'(TxD), 32'd1);
        chk("mid rst busy", 32'(Tx_BUSY), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post rst busy", 32'(Tx_BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
